// File: rtl/clock_switch_pkg.sv
// Shared types and helpers for the clock-source sequencer: FSM state encoding,
// channel limit and the sizing rule for the gate/settle wait counter.
package clock_switch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_GATE   = 2'd1,
        ST_SWITCH = 2'd2
    } switch_state_t;

    localparam int MAX_CLKS = 16;

    // The wait counter is loaded with (length - 1) and counts down to zero,
    // so it only needs to hold the longer of the two phases minus one.
    function automatic int wait_cnt_width(input int gate_wait, input int settle);
        int longest;
        longest = (gate_wait > settle) ? gate_wait : settle;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/clk_presence_mon.sv
// Per-channel heartbeat presence monitor: synchronise each toggle, count its
// edges over a shared window and publish a presence bit at every window end.
module clk_presence_mon
    import clock_switch_pkg::*;
#(
    parameter int pN_CLKS    = 4,
    parameter int pWINDOW    = 1024,
    parameter int pMIN_EDGES = 4
) (
    input  logic               usb_clk,
    input  logic               reset_n,
    input  logic [pN_CLKS-1:0] heartbeat,
    output logic [pN_CLKS-1:0] present,
    output logic               present_valid
);

    localparam int CNT_W = $clog2(pMIN_EDGES + 1);
    localparam int WIN_W = (pWINDOW > 1) ? $clog2(pWINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(pWINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(pMIN_EDGES);

    logic [pN_CLKS-1:0] sync1_reg;
    logic [pN_CLKS-1:0] sync2_reg;
    logic [pN_CLKS-1:0] sync3_reg;
    logic [pN_CLKS-1:0] edge_seen;
    logic [WIN_W-1:0]   win_cnt_reg;
    logic               win_end;
    logic               present_valid_reg;

    // sync1/sync2 resolve metastability; sync3 holds the previous settled value
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            sync3_reg <= '0;
        end else begin
            sync1_reg <= heartbeat;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign edge_seen = sync2_reg ^ sync3_reg;
    assign win_end   = (win_cnt_reg == WIN_LAST);

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt_reg       <= '0;
            present_valid_reg <= 1'b0;
        end else if (win_end) begin
            win_cnt_reg       <= '0;
            present_valid_reg <= 1'b1;
        end else begin
            win_cnt_reg <= win_cnt_reg + WIN_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < pN_CLKS; gi++) begin : g_chan
            logic [CNT_W-1:0] edge_cnt_reg;
            logic             chan_present_reg;

            // An edge seen on the terminal cycle seeds the next window's count.
            always_ff @(posedge usb_clk or negedge reset_n) begin
                if (!reset_n) begin
                    edge_cnt_reg     <= '0;
                    chan_present_reg <= 1'b0;
                end else if (win_end) begin
                    chan_present_reg <= (edge_cnt_reg >= CNT_SAT);
                    edge_cnt_reg     <= CNT_W'(edge_seen[gi]);
                end else if (edge_seen[gi] && (edge_cnt_reg != CNT_SAT)) begin
                    edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
                end
            end

            assign present[gi] = chan_present_reg;
        end
    endgenerate

    assign present_valid = present_valid_reg;

endmodule

// File: rtl/clock_switch_ctrl.sv
// Glitch-safe clock-source sequencer: every source change is gated, switched,
// allowed to settle and ungated; optional fallback to source 0 on clock loss.
module clock_switch_ctrl
    import clock_switch_pkg::*;
#(
    parameter int pN_CLKS    = 4,
    parameter int pSEL_W     = $clog2(pN_CLKS),
    parameter int pWINDOW    = 1024,
    parameter int pMIN_EDGES = 4,
    parameter int pGATE_WAIT = 8,
    parameter int pSETTLE    = 64
) (
    input  logic               usb_clk,
    input  logic               reset_n,
    input  logic [pSEL_W-1:0]  I_sel_req,
    input  logic               I_sel_valid,
    input  logic               I_auto_fallback,
    input  logic               I_fault_clr,
    input  logic [pN_CLKS-1:0] I_clk_heartbeat,
    output logic [pSEL_W-1:0]  O_clk_sel,
    output logic               O_clk_en,
    output logic               O_busy,
    output logic [pN_CLKS-1:0] O_clk_present,
    output logic               O_present_valid,
    output logic               O_fault
);

    localparam int WAIT_W = wait_cnt_width(pGATE_WAIT, pSETTLE);
    localparam logic [WAIT_W-1:0] GATE_LOAD   = WAIT_W'(pGATE_WAIT - 1);
    localparam logic [WAIT_W-1:0] SETTLE_LOAD = WAIT_W'(pSETTLE - 1);

    switch_state_t      state_reg, state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [pSEL_W-1:0]  target_reg, target_next;
    logic [pSEL_W-1:0]  clk_sel_reg, clk_sel_next;
    logic               clk_en_reg, clk_en_next;
    logic               busy_reg, busy_next;
    logic               fault_reg, fault_next;
    logic               fault_set;

    logic [pN_CLKS-1:0] clk_present;
    logic               present_valid;
    logic               active_lost;
    logic               fallback_go;
    logic               req_in_range;
    logic               req_present;

    clk_presence_mon #(
        .pN_CLKS    (pN_CLKS),
        .pWINDOW    (pWINDOW),
        .pMIN_EDGES (pMIN_EDGES)
    ) u_presence (
        .usb_clk       (usb_clk),
        .reset_n       (reset_n),
        .heartbeat     (I_clk_heartbeat),
        .present       (clk_present),
        .present_valid (present_valid)
    );

    assign req_in_range = (int'(I_sel_req) < pN_CLKS);
    assign req_present  = req_in_range && clk_present[I_sel_req];

    // Loss of the active source; only actionable if source 0 is itself alive.
    assign active_lost = I_auto_fallback && present_valid &&
                         !clk_present[clk_sel_reg] && (clk_sel_reg != '0);
    assign fallback_go = active_lost && clk_present[0];

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
            target_reg   <= '0;
            clk_sel_reg  <= '0;
            clk_en_reg   <= 1'b1;
            busy_reg     <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            target_reg   <= target_next;
            clk_sel_reg  <= clk_sel_next;
            clk_en_reg   <= clk_en_next;
            busy_reg     <= busy_next;
            fault_reg    <= fault_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        target_next   = target_reg;
        fault_set     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (active_lost) begin
                    fault_set = 1'b1;
                end
                // Fallback pre-empts any request arriving in the same cycle.
                if (fallback_go) begin
                    target_next   = '0;
                    wait_cnt_next = GATE_LOAD;
                    state_next    = ST_GATE;
                end else if (I_sel_valid) begin
                    if (!req_in_range || !present_valid || !req_present) begin
                        fault_set = 1'b1;
                    end else if (I_sel_req != clk_sel_reg) begin
                        target_next   = I_sel_req;
                        wait_cnt_next = GATE_LOAD;
                        state_next    = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                if (wait_cnt_reg == '0) begin
                    wait_cnt_next = SETTLE_LOAD;
                    state_next    = ST_SWITCH;
                end else begin
                    wait_cnt_next = wait_cnt_reg - WAIT_W'(1);
                end
            end
            ST_SWITCH: begin
                if (wait_cnt_reg == '0) begin
                    state_next = ST_RUN;
                end else begin
                    wait_cnt_next = wait_cnt_reg - WAIT_W'(1);
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        clk_en_next  = (state_next == ST_RUN);
        busy_next    = (state_next != ST_RUN);
        clk_sel_next = clk_sel_reg;
        if ((state_reg == ST_GATE) && (state_next == ST_SWITCH)) begin
            clk_sel_next = target_reg;
        end
        fault_next = fault_reg;
        if (I_fault_clr) begin
            fault_next = 1'b0;
        end
        if (fault_set) begin
            fault_next = 1'b1;
        end
    end

    assign O_clk_sel       = clk_sel_reg;
    assign O_clk_en        = clk_en_reg;
    assign O_busy          = busy_reg;
    assign O_clk_present   = clk_present;
    assign O_present_valid = present_valid;
    assign O_fault         = fault_reg;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Bench for clock_switch_ctrl: a timeline model of the sequencer checked every
// cycle, plus directed literal checks at hand-computed cycles.
module tb_clock_switch_ctrl;

    localparam int N_CLKS    = 4;
    localparam int SEL_W     = 2;
    localparam int WINDOW    = 64;
    localparam int MIN_EDGES = 4;
    localparam int GATE_WAIT = 4;
    localparam int SETTLE    = 8;
    localparam int N_WIN     = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [SEL_W-1:0]  sel_req = '0;
    logic              sel_valid = 1'b0;
    logic              auto_fb = 1'b0;
    logic              fault_clr = 1'b0;
    logic [N_CLKS-1:0] hb = '0;
    logic [N_CLKS-1:0] hb_en = '0;

    logic [SEL_W-1:0]  o_sel;
    logic              o_en, o_busy, o_pv, o_fault;
    logic [N_CLKS-1:0] o_present;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Model state
    int                m_sel, m_target, seq_t;
    logic              seq_on, m_pv, m_fault, set_f, lost;
    logic [N_CLKS-1:0] m_present, hb_prev;
    int                win_edges [N_CLKS][N_WIN];

    always #5 clk = ~clk;

    clock_switch_ctrl #(
        .pN_CLKS    (N_CLKS),
        .pWINDOW    (WINDOW),
        .pMIN_EDGES (MIN_EDGES),
        .pGATE_WAIT (GATE_WAIT),
        .pSETTLE    (SETTLE)
    ) dut (
        .usb_clk         (clk),
        .reset_n         (reset_n),
        .I_sel_req       (sel_req),
        .I_sel_valid     (sel_valid),
        .I_auto_fallback (auto_fb),
        .I_fault_clr     (fault_clr),
        .I_clk_heartbeat (hb),
        .O_clk_sel       (o_sel),
        .O_clk_en        (o_en),
        .O_busy          (o_busy),
        .O_clk_present   (o_present),
        .O_present_valid (o_pv),
        .O_fault         (o_fault)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic go_to(input int n);
        int guard = 0;
        while (cyc < n) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 5000) begin
                n_checks++;
                n_fail++;
                $display("FAIL go_to timeout: reached cycle %0d, required %0d", cyc, n);
                $fatal(1, "cycle budget exhausted");
            end
        end
    endtask

    task automatic at_neg(input int n);
        go_to(n);
        @(negedge clk);
    endtask

    task automatic strobe(input int n, input int sel);
        go_to(n);
        $display("txn cycle %0d: request source %0d", n, sel);
        sel_req   = SEL_W'(sel);
        sel_valid = 1'b1;
        go_to(n + 1);
        sel_valid = 1'b0;
    endtask

    task automatic pulse_clr(input int n);
        go_to(n);
        $display("txn cycle %0d: fault clear", n);
        fault_clr = 1'b1;
        go_to(n + 1);
        fault_clr = 1'b0;
    endtask

    // Heartbeats toggle every 4 cycles on enabled channels
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && (cyc % 4 == 0)) hb = hb ^ hb_en;
        end
    end

    // Timeline model and per-cycle compare
    always @(negedge clk) begin
        if (!reset_n) begin
            m_sel = 0; m_target = 0; seq_t = 0; seq_on = 1'b0;
            m_pv = 1'b0; m_fault = 1'b0; m_present = '0; hb_prev = '0;
            for (int i = 0; i < N_CLKS; i++)
                for (int w = 0; w < N_WIN; w++) win_edges[i][w] = 0;
            check("rst_sel", 32'(o_sel), 0);
            check("rst_en", 32'(o_en), 1);
            check("rst_busy", 32'(o_busy), 0);
            check("rst_fault", 32'(o_fault), 0);
            check("rst_pv", 32'(o_pv), 0);
            check("rst_present", 32'(o_present), 0);
        end else begin
            // Window k closes at cycle k*WINDOW and judges edges counted in it
            if (cyc > 0 && cyc % WINDOW == 0 && cyc / WINDOW < N_WIN) begin
                m_pv = 1'b1;
                for (int i = 0; i < N_CLKS; i++)
                    m_present[i] = (win_edges[i][cyc / WINDOW] >= MIN_EDGES);
            end
            if (seq_on && cyc == seq_t + 1 + GATE_WAIT) m_sel = m_target;
            if (seq_on && cyc == seq_t + 1 + GATE_WAIT + SETTLE) seq_on = 1'b0;

            check("sel", 32'(o_sel), 32'(m_sel));
            check("en", 32'(o_en), 32'(!seq_on));
            check("busy", 32'(o_busy), 32'(seq_on));
            check("fault", 32'(o_fault), 32'(m_fault));
            check("pv", 32'(o_pv), 32'(m_pv));
            check("present", 32'(o_present), 32'(m_present));

            // A toggle seen in cycle c reaches the edge counter 3 cycles later
            for (int i = 0; i < N_CLKS; i++) begin
                if (hb[i] !== hb_prev[i]) begin
                    if ((cyc + 3) / WINDOW + 1 < N_WIN)
                        win_edges[i][(cyc + 3) / WINDOW + 1]++;
                end
            end
            hb_prev = hb;

            set_f = 1'b0;
            if (!seq_on) begin
                lost = auto_fb && m_pv && !m_present[m_sel] && (m_sel != 0);
                if (lost) begin
                    set_f = 1'b1;
                    if (m_present[0]) begin
                        seq_on = 1'b1; seq_t = cyc; m_target = 0;
                    end
                end
                if (!(lost && m_present[0]) && sel_valid) begin
                    if (int'(sel_req) >= N_CLKS || !m_pv || !m_present[sel_req]) begin
                        set_f = 1'b1;
                    end else if (int'(sel_req) != m_sel) begin
                        seq_on = 1'b1; seq_t = cyc; m_target = int'(sel_req);
                    end
                end
            end
            if (set_f)          m_fault = 1'b1;
            else if (fault_clr) m_fault = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        hb_en = 4'b0111;
        @(negedge clk);
        check("lit_reset_en", 32'(o_en), 1);
        check("lit_reset_sel", 32'(o_sel), 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // Request before the first window has completed
        strobe(10, 2);
        at_neg(11);
        check("lit_prewin_fault", 32'(o_fault), 1);
        check("lit_prewin_en", 32'(o_en), 1);
        pulse_clr(20);
        at_neg(21);
        check("lit_clr_alone", 32'(o_fault), 0);

        at_neg(70);
        check("lit_present_w1", 32'(o_present), 32'h7);
        check("lit_pv_w1", 32'(o_pv), 1);

        // Full switch to source 2
        strobe(72, 2);
        at_neg(73);
        check("lit_sw_en_t1", 32'(o_en), 0);
        check("lit_sw_busy_t1", 32'(o_busy), 1);
        at_neg(76);
        check("lit_sw_sel_t4", 32'(o_sel), 0);
        at_neg(77);
        check("lit_sw_sel_t5", 32'(o_sel), 2);
        at_neg(84);
        check("lit_sw_en_t12", 32'(o_en), 0);
        at_neg(85);
        check("lit_sw_en_t13", 32'(o_en), 1);
        check("lit_sw_busy_t13", 32'(o_busy), 0);

        // Absent source, then same-source no-op
        strobe(90, 3);
        at_neg(91);
        check("lit_absent_fault", 32'(o_fault), 1);
        check("lit_absent_en", 32'(o_en), 1);
        pulse_clr(93);
        strobe(96, 2);
        at_neg(97);
        check("lit_noop_fault", 32'(o_fault), 0);
        check("lit_noop_busy", 32'(o_busy), 0);

        // Clear coinciding with a rejection: set wins
        go_to(100);
        $display("txn cycle 100: request source 3 with fault clear");
        sel_req = 2'd3; sel_valid = 1'b1; fault_clr = 1'b1;
        go_to(101);
        sel_valid = 1'b0; fault_clr = 1'b0;
        at_neg(101);
        check("lit_clr_vs_set", 32'(o_fault), 1);
        pulse_clr(105);
        at_neg(106);
        check("lit_clr_after", 32'(o_fault), 0);

        // Heartbeat 2 stops; fallback fires when window 3 closes at cycle 192
        go_to(110);
        $display("txn cycle 110: auto fallback on, heartbeat 2 stopped");
        auto_fb = 1'b1;
        hb_en   = 4'b0011;
        at_neg(150);
        check("lit_w2_present", 32'(o_present), 32'h7);
        check("lit_w2_sel", 32'(o_sel), 2);
        strobe(192, 1);
        at_neg(193);
        check("lit_fb_present", 32'(o_present), 32'h3);
        check("lit_fb_fault", 32'(o_fault), 1);
        check("lit_fb_busy", 32'(o_busy), 1);
        at_neg(197);
        check("lit_fb_sel", 32'(o_sel), 0);
        at_neg(205);
        check("lit_fb_en", 32'(o_en), 1);
        at_neg(207);
        check("lit_fb_req_dropped", 32'(o_sel), 0);

        // Reset in the middle of SWITCH
        pulse_clr(210);
        strobe(212, 1);
        at_neg(218);
        check("lit_pre_rst_sel", 32'(o_sel), 1);
        go_to(220);
        $display("txn cycle 220: reset pulse during switch");
        #1 reset_n = 1'b0;
        #1;
        check("lit_async_rst_sel", 32'(o_sel), 0);
        check("lit_async_rst_en", 32'(o_en), 1);
        check("lit_async_rst_busy", 32'(o_busy), 0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        at_neg(66);
        check("lit_post_rst_present", 32'(o_present), 32'h3);
        check("lit_post_rst_pv", 32'(o_pv), 1);
        go_to(70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
